// File: rtl/wb_uart_tx.sv
// wb_uart_tx: Wishbone B3 classic slave UART transmitter (8N1, LSB first).
// CPU stores land in a small TX FIFO which drains onto tx_o at CLK_DIV
// clocks per bit. irq_o is a level interrupt signalling a fully drained
// transmitter.
module wb_uart_tx #(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic        tx_o,
  output logic        irq_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [DIV_W-1:0] BAUD_RELOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] BAUD_ONE    = DIV_W'(1);
  localparam logic [DIV_W-1:0] BAUD_ZERO   = '0;
  localparam logic [CW-1:0]    CNT_FULL    = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]    CNT_ONE     = CW'(1);
  localparam logic [CW-1:0]    CNT_ZERO    = '0;
  localparam logic [AW-1:0]    PTR_ONE     = AW'(1);

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // Bus-side state
  logic        ack_q;
  logic [31:0] dat_q, dat_d;
  logic        irq_en_q;
  logic        ovf_q;
  logic        irq_q;

  // FIFO state
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Transmitter state
  state_t           state_q, state_d;
  logic [DIV_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;

  // Decode and handshake
  logic        req;
  logic [1:0]  reg_sel;
  logic        wr_txdata, wr_ctrl, rd_status;
  logic        fifo_empty, fifo_full;
  logic        push, pop;
  logic        busy;
  logic [31:0] rdata;
  logic        unused_bits;

  // Byte selects, sub-word address bits and the upper data byte lanes are
  // don't-care: every access is treated as a full 32-bit word.
  assign unused_bits = ^{wb_sel_i, wb_adr_i[1:0], wb_dat_i[31:8]};

  // A new request is only accepted when ack is low, so a held strobe
  // produces ack on alternate cycles.
  assign req       = wb_stb_i & wb_cyc_i & ~ack_q;
  assign reg_sel   = wb_adr_i[3:2];
  assign wr_txdata = req &  wb_we_i & (reg_sel == REG_TXDATA);
  assign wr_ctrl   = req &  wb_we_i & (reg_sel == REG_CTRL);
  assign rd_status = req & ~wb_we_i & (reg_sel == REG_STATUS);

  // Full/empty come from pre-edge occupancy; a same-cycle pop never frees
  // room for a push into a full FIFO.
  assign fifo_empty = (cnt_q == CNT_ZERO);
  assign fifo_full  = (cnt_q == CNT_FULL);
  assign push       = wr_txdata & ~fifo_full;
  assign busy       = (state_q != S_IDLE);

  // Read mux for the register map; unmapped and write-only reads return 0.
  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_STATUS: rdata = {27'd0, ovf_q, irq_en_q, busy, fifo_full, fifo_empty};
      REG_CTRL:   rdata = {31'd0, irq_en_q};
      default:    rdata = '0;
    endcase
    dat_d = (req & ~wb_we_i) ? rdata : 32'd0;
  end

  // Bus registers: single-cycle ack, registered read data, CTRL and ovf.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      ack_q <= req;
      dat_q <= dat_d;
      if (wr_ctrl) begin
        irq_en_q <= wb_dat_i[0];
      end
      if (wr_txdata & fifo_full) begin
        ovf_q <= 1'b1;
      end else if (rd_status) begin
        ovf_q <= 1'b0;
      end
    end
  end

  // FIFO storage is pure data and carries no reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wb_dat_i[7:0];
    end
  end

  // Occupancy next-state from the push/pop pair.
  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      cnt_q <= cnt_d;
    end
  end

  // Transmit FSM: next state, baud/bit counters, shifter and line level.
  // The line level is derived from the next state so tx_o is a clean
  // register output that changes on the same edge as the state.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          bit_d   = 3'd0;
          baud_d  = BAUD_RELOAD;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_q == BAUD_ZERO) begin
          baud_d  = BAUD_RELOAD;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q - BAUD_ONE;
        end
      end
      S_DATA: begin
        if (baud_q == BAUD_ZERO) begin
          baud_d  = BAUD_RELOAD;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - BAUD_ONE;
        end
      end
      S_STOP: begin
        if (baud_q == BAUD_ZERO) begin
          if (!fifo_empty) begin
            // Chain straight into the next start bit: no idle gap.
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            bit_d   = 3'd0;
            baud_d  = BAUD_RELOAD;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q - BAUD_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    tx_d = 1'b1;
    if (state_d == S_START) begin
      tx_d = 1'b0;
    end else if (state_d == S_DATA) begin
      tx_d = shift_d[0];
    end
  end

  // Transmit control registers; reset aborts any frame and idles the line.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  // Shift register holds only frame data and needs no reset.
  always_ff @(posedge clk_i) begin
    shift_q <= shift_d;
  end

  // Drained interrupt, registered from pre-edge state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_en_q & fifo_empty & (state_q == S_IDLE);
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign tx_o     = tx_q;
  assign irq_o    = irq_q;

endmodule

// File: doc/wb_uart_tx.md
Name: wb_uart_tx

Overview:
Wishbone B3 classic slave UART transmitter (8N1, LSB first), the first serial-output peripheral on the or1200_sopc data bus. It sits directly downstream of the CPU data port: CPU stores go into a small TX FIFO, and the FIFO drains onto tx_o at a fixed baud rate. A level interrupt tells the CPU when the transmitter has fully drained.

Parameters:
CLK_DIV, 434, clock cycles per bit (50 MHz / 115200); legal range 2..65535
FIFO_DEPTH, 8, TX FIFO entries; power of 2, minimum 2
DIV_W, 16, width of the baud counter; must satisfy 2^DIV_W > CLK_DIV

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous reset, active-high
wb_adr_i  in  4  byte address; decode uses [3:2] only
wb_dat_i  in  32  write data
wb_dat_o  out  32  read data
wb_sel_i  in  4  byte selects; ignored (full-word access)
wb_we_i  in  1  write enable
wb_stb_i  in  1  strobe
wb_cyc_i  in  1  cycle valid
wb_ack_o  out  1  single-cycle acknowledge
tx_o  out  1  serial output, idles high
irq_o  out  1  TX-drained interrupt, level

Behaviour:
- Reset (async, rst_i=1): tx_o=1, wb_ack_o=0, wb_dat_o=0, irq_o=0; FIFO emptied; FSM=IDLE; irq_en=0; ovf=0; baud counter=0. Asserting reset mid-frame aborts the frame and forces tx_o high immediately.
- Register map (adr[3:2]):
  - 0 TXDATA: write pushes wb_dat_i[7:0]; read returns 0.
  - 1 STATUS (RO): bit0 fifo_empty, bit1 fifo_full, bit2 busy (FSM!=IDLE), bit3 irq_en, bit4 ovf. A read clears ovf at the ack edge.
  - 2 CTRL: bit0 irq_en (R/W).
  - 3: reads 0; writes ignored.
- Bus handshake: request = stb & cyc & !ack.
  - A request sampled at edge k drives ack=1 during cycle k..k+1. ack drops at edge k+1, so ack is never high two cycles in a row.
  - The register side effect (push, CTRL write, ovf clear) occurs at edge k.
  - wb_dat_o is valid while ack=1 and 0 otherwise.
  - Zero wait states. Every access is acked, including unmapped addresses.
- FIFO: FIFO_DEPTH entries with a log2+1-bit occupancy count.
  - full and empty are evaluated on pre-edge state.
  - Push when full: data is dropped, ovf is set, and ack is still given. A pop in the same cycle does not make room.
  - Pop only when non-empty pre-edge, so push-to-empty followed by pop takes two edges.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx_o=1. If FIFO non-empty, pop the head into shift register, bit_cnt=0, baud_cnt=CLK_DIV-1, go to START.
  - START: tx_o=0 for CLK_DIV cycles, then go to DATA.
  - DATA: tx_o=shift[0] for CLK_DIV cycles per bit. Shift right after each bit; after bit_cnt reaches 7, go to STOP.
  - STOP: tx_o=1 for CLK_DIV cycles. At the end, if FIFO non-empty, pop and go straight to START (no idle cycle); else go to IDLE.
  - Baud counter reloads CLK_DIV-1 and decrements. The state or bit advances when it reaches 0.
  - Each frame is exactly 10*CLK_DIV cycles; back-to-back frames are contiguous.
- Latency: a TXDATA write acked at edge k with FSM IDLE and FIFO empty pops at edge k+1, so tx_o falls after edge k+1.
- irq_o is registered: irq_o = irq_en & fifo_empty & (FSM==IDLE). It asserts the cycle after the last stop bit completes, and clears on the next push or on irq_en=0.
- No parity or RX. CLK_DIV is fixed at elaboration.

Test Plan:
- Reset: with rst_i pulsed mid-frame (CLK_DIV=4) -> tx_o=1 and STATUS=0x01 after reset; no further edges on tx_o.
- Single byte: CLK_DIV=4, write 0x55 to TXDATA -> ack exactly 1 cycle; tx_o falls after the next edge; pattern 0,1,0,1,0,1,0,1,0,1, 4 cycles each (40 total); then tx_o stays 1 and STATUS=0x01.
- Back-to-back: write 0xA5, 0x3C, 0xFF in consecutive bus cycles -> three contiguous frames of 120 cycles total, with no idle between stop and start bits; decoded bytes A5, 3C, FF.
- Overflow: FIFO_DEPTH=8, write 10 bytes fast while transmitting slowly (CLK_DIV=100) -> 9 bytes sent (1 popped immediately plus 8 queued), the 10th is dropped; STATUS bit4=1 and all 10 writes acked; a second STATUS read shows bit4=0.
- Interrupt: write CTRL=1 with FIFO idle -> irq_o=1 next cycle; write 0x00 -> irq_o=0 the cycle after the push; irq_o returns to 1 one cycle after the stop bit ends; write CTRL=0 -> irq_o=0.
- Bus protocol: stb held high for 4 cycles on a STATUS read -> ack pattern 1,0,1,0 (request gated by !ack); stb without cyc -> no ack and no side effect.
